bshaper_multi: RTL

BSHAPER_MULTI -- requirements
Module: bshaper_multi

---
 rtl/bshaper_multi.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bshaper_multi.sv
// bshaper_multi: per-channel button synchronizer, debouncer and press/auto-repeat
// pulse shaper. Buttons are active-low. Each channel runs its own small FSM and
// has no shared state with the other channels.
module bshaper_multi #(
    parameter int N_CH    = 4,
    parameter int DB_CYC  = 4,
    parameter int REP_EN  = 0,
    parameter int REP_DLY = 16,
    parameter int REP_PER = 8,
    parameter int CNT_W   = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] button_in,
    output logic [N_CH-1:0] button_out,
    output logic [N_CH-1:0] held_out
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_HELD     = 2'd2,
        ST_REL_DB   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] ZERO    = '0;
    localparam logic [CNT_W-1:0] DB_LIM  = CNT_W'(DB_CYC);
    localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(REP_DLY);
    localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(REP_PER);
    localparam logic             REP_ON  = (REP_EN != 32'sd0);

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : (v + ONE);
    endfunction

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_db_cnt;
        logic [CNT_W-1:0] w_db_cnt_nxt;
        logic [CNT_W-1:0] r_rep_cnt;
        logic [CNT_W-1:0] w_rep_cnt_nxt;
        logic             r_rep_first;      // first repeat already issued in this hold
        logic             w_rep_first_nxt;
        logic             r_pulse;
        logic             w_pulse_nxt;
        logic             r_held;
        logic             w_held_nxt;
        logic             w_pressed;
        logic [CNT_W-1:0] w_db_inc;
        logic [CNT_W-1:0] w_rep_inc;

        assign w_pressed = ~r_sync2;
        assign w_db_inc  = sat_inc(r_db_cnt);
        assign w_rep_inc = sat_inc(r_rep_cnt);

        // Two-flop synchronizer; reset value 1 means "released".
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= button_in[g];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce/repeat FSM: next state, counters and output pulse.
        always_comb begin
            w_state_nxt     = r_state;
            w_db_cnt_nxt    = r_db_cnt;
            w_rep_cnt_nxt   = r_rep_cnt;
            w_rep_first_nxt = r_rep_first;
            w_pulse_nxt     = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    w_rep_cnt_nxt   = ZERO;
                    w_rep_first_nxt = 1'b0;
                    if (w_pressed) begin
                        if (DB_LIM == ONE) begin
                            // single-cycle debounce accepts straight away
                            w_state_nxt  = ST_HELD;
                            w_db_cnt_nxt = ZERO;
                            w_pulse_nxt  = 1'b1;
                        end else begin
                            w_state_nxt  = ST_PRESS_DB;
                            w_db_cnt_nxt = ONE;
                        end
                    end else begin
                        w_db_cnt_nxt = ZERO;
                    end
                end
                ST_PRESS_DB: begin
                    if (w_pressed) begin
                        if (w_db_inc >= DB_LIM) begin
                            w_state_nxt     = ST_HELD;
                            w_db_cnt_nxt    = ZERO;
                            w_rep_cnt_nxt   = ZERO;
                            w_rep_first_nxt = 1'b0;
                            w_pulse_nxt     = 1'b1;
                        end else begin
                            w_db_cnt_nxt = w_db_inc;
                        end
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_db_cnt_nxt = ZERO;
                    end
                end
                ST_HELD: begin
                    if (!w_pressed) begin
                        if (DB_LIM == ONE) begin
                            w_state_nxt     = ST_IDLE;
                            w_db_cnt_nxt    = ZERO;
                            w_rep_cnt_nxt   = ZERO;
                            w_rep_first_nxt = 1'b0;
                        end else begin
                            w_state_nxt  = ST_REL_DB;
                            w_db_cnt_nxt = ONE;
                        end
                    end else if (REP_ON) begin
                        // repeat timer restarts after every repeat pulse
                        if (!r_rep_first && (w_rep_inc >= DLY_LIM)) begin
                            w_pulse_nxt     = 1'b1;
                            w_rep_cnt_nxt   = ZERO;
                            w_rep_first_nxt = 1'b1;
                        end else if (r_rep_first && (w_rep_inc >= PER_LIM)) begin
                            w_pulse_nxt   = 1'b1;
                            w_rep_cnt_nxt = ZERO;
                        end else begin
                            w_rep_cnt_nxt = w_rep_inc;
                        end
                    end else begin
                        w_rep_cnt_nxt = ZERO;
                    end
                end
                ST_REL_DB: begin
                    if (w_pressed) begin
                        // release was a glitch: resume hold, repeat timer keeps its value
                        w_state_nxt  = ST_HELD;
                        w_db_cnt_nxt = ZERO;
                    end else if (w_db_inc >= DB_LIM) begin
                        w_state_nxt     = ST_IDLE;
                        w_db_cnt_nxt    = ZERO;
                        w_rep_cnt_nxt   = ZERO;
                        w_rep_first_nxt = 1'b0;
                    end else begin
                        w_db_cnt_nxt = w_db_inc;
                    end
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_db_cnt_nxt    = ZERO;
                    w_rep_cnt_nxt   = ZERO;
                    w_rep_first_nxt = 1'b0;
                end
            endcase
            w_held_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REL_DB);
        end

        // State, counters and registered outputs.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_state     <= ST_IDLE;
                r_db_cnt    <= ZERO;
                r_rep_cnt   <= ZERO;
                r_rep_first <= 1'b0;
                r_pulse     <= 1'b0;
                r_held      <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_db_cnt    <= w_db_cnt_nxt;
                r_rep_cnt   <= w_rep_cnt_nxt;
                r_rep_first <= w_rep_first_nxt;
                r_pulse     <= w_pulse_nxt;
                r_held      <= w_held_nxt;
            end
        end

        assign button_out[g] = r_pulse;
        assign held_out[g]   = r_held;
    end

endmodule
